// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - RV32I operand fetch stage for R-type and I-type ALU ops
//
// Purpose: holds the 32x32 register file, decodes an accepted instruction,
// reads its source operands (with same-cycle writeback bypass) and presents
// one registered ALU operation to the next stage under a valid/ready
// handshake. Non-ALU opcodes are dropped and counted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/instr  upstream instruction handshake
//   wb_en/wb_rd/wb_data      register-file write port from writeback
//   out_valid/out_ready      downstream handshake
//   opcode/funct7/funct3     registered decode fields
//   a/b/rd                   registered operands and destination index
//   illegal_cnt              saturating count of dropped instructions

module operand_fetch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       opcode,
  output logic [6:0]       funct7,
  output logic [2:0]       funct3,
  output logic [31:0]      a,
  output logic [31:0]      b,
  output logic [4:0]       rd,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic [31:0] regs [32];

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  dec_f3;
  logic [6:0]  dec_op;
  logic        is_r;
  logic        is_i;
  logic        is_shift;
  logic        accept;
  logic        consume;
  logic        legal;
  logic        wb_hit;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [6:0]  dec_f7;
  logic [31:0] dec_b;

  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign dec_f3   = instr[14:12];
  assign dec_op   = instr[6:0];
  assign is_r     = (dec_op == OP_R);
  assign is_i     = (dec_op == OP_I);
  assign legal    = is_r || is_i;
  assign is_shift = (dec_f3 == 3'b001) || (dec_f3 == 3'b101);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign wb_hit   = wb_en && (wb_rd != 5'd0);

  // Register read with writeback bypass; x0 is hardwired to zero.
  always_comb begin
    rs1_val = regs[rs1];
    if (rs1 == 5'd0) begin
      rs1_val = 32'd0;
    end else if (wb_hit && (wb_rd == rs1)) begin
      rs1_val = wb_data;
    end
    rs2_val = regs[rs2];
    if (rs2 == 5'd0) begin
      rs2_val = 32'd0;
    end else if (wb_hit && (wb_rd == rs2)) begin
      rs2_val = wb_data;
    end
  end

  // Operand B / funct7 selection. Immediate shifts carry their shamt in the
  // rs2 field and their arithmetic/logical selector in instr[31:25].
  always_comb begin
    dec_f7 = 7'd0;
    dec_b  = {{20{instr[31]}}, instr[31:20]};
    if (is_r) begin
      dec_f7 = instr[31:25];
      dec_b  = rs2_val;
    end else if (is_shift) begin
      dec_f7 = instr[31:25];
      dec_b  = {27'd0, instr[24:20]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
      out_valid   <= 1'b0;
      opcode      <= 7'd0;
      funct7      <= 7'd0;
      funct3      <= 3'd0;
      a           <= 32'd0;
      b           <= 32'd0;
      rd          <= 5'd0;
      illegal_cnt <= '0;
    end else begin
      if (wb_hit) begin
        regs[wb_rd] <= wb_data;
      end

      if (accept && legal) begin
        out_valid <= 1'b1;
        opcode    <= dec_op;
        funct7    <= dec_f7;
        funct3    <= dec_f3;
        a         <= rs1_val;
        b         <= dec_b;
        rd        <= instr[11:7];
      end else if (consume) begin
        // Covers a dropped instruction in the consume cycle as well.
        out_valid <= 1'b0;
      end

      if (accept && !legal && (illegal_cnt != {CNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch

module tb_operand_fetch;

  localparam int CW = 3;
  localparam logic [31:0] ADD_X7_X5_X6 = 32'h006283B3;
  localparam logic [31:0] ADD_X7_X0_X6 = 32'h006003B3;
  localparam logic [31:0] ADDI_X1_M1   = 32'hFFF00093;
  localparam logic [31:0] SRAI_X2_X1_4 = 32'h4040D113;
  localparam logic [31:0] LW_X5        = 32'h00002283;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } op_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr;
  logic          wb_en;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [6:0]    opcode;
  logic [6:0]    funct7;
  logic [2:0]    funct3;
  logic [31:0]   a;
  logic [31:0]   b;
  logic [4:0]    rd;
  logic [CW-1:0] illegal_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_rf [32];
  logic        m_valid;
  op_t         m_out;
  int          m_cnt;

  op_t obs;
  assign obs = {opcode, funct7, funct3, a, b, rd};

  always #5 clk = ~clk;

  operand_fetch #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .funct7(funct7), .funct3(funct3), .a(a), .b(b), .rd(rd),
    .illegal_cnt(illegal_cnt)
  );

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic op_t m_decode(input logic [31:0] ins);
    op_t o;
    logic shift;
    o = '0;
    o.opcode = ins[6:0];
    o.f3 = ins[14:12];
    o.rd = ins[11:7];
    o.a = m_read(ins[19:15]);
    if (ins[6:0] == 7'b0110011) begin
      o.f7 = ins[31:25];
      o.b = m_read(ins[24:20]);
    end else begin
      shift = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
      o.f7 = shift ? ins[31:25] : 7'd0;
      o.b = shift ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
    end
    return o;
  endfunction

  function automatic logic [31:0] rand_instr(input bit allow_illegal);
    logic [31:0] ins;
    int sel;
    ins = $urandom;
    sel = allow_illegal ? $urandom_range(0, 9) : $urandom_range(0, 7);
    if (sel < 4) begin
      ins[6:0] = 7'b0110011;
      ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end else if (sel < 8) begin
      ins[6:0] = 7'b0010011;
    end else if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) begin
      ins[6:0] = 7'b0000011;
    end
    return ins;
  endfunction

  // Advance the reference model by one clock using the currently driven
  // inputs, then move to 1 time unit past the rising edge.
  task automatic tick();
    bit acc, legal;
    op_t d;
    if (rst) begin
      m_valid = 1'b0;
      m_out = '0;
      m_cnt = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      legal = (instr[6:0] == 7'b0110011) || (instr[6:0] == 7'b0010011);
      d = m_decode(instr);
      if (acc && legal) begin
        m_out = d;
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (acc && !legal && m_cnt < (1 << CW) - 1) m_cnt++;
      if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    in_valid = 1'b0;
    instr = 32'd0;
    wb_en = 1'b0;
    wb_rd = 5'd0;
    wb_data = 32'd0;
    out_ready = 1'b1;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    idle();
    wb_en = 1'b1;
    wb_rd = r;
    wb_data = v;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    in_valid = 1'b1;
    instr = ADD_X7_X5_X6;
    wb_en = 1'b1;
    wb_rd = 5'd5;
    wb_data = 32'hFFFF_FFFF;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (obs !== op_t'(0) || illegal_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h cnt %0d want 0 cnt 0", obs, illegal_cnt);
    end
    idle();
  endtask

  task automatic test_r_type();
    write_reg(5'd5, 32'hA);
    write_reg(5'd6, 32'h3);
    idle();
    in_valid = 1'b1;
    instr = ADD_X7_X5_X6;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || obs !== {7'h33, 7'h00, 3'h0, 32'hA, 32'h3, 5'd7}) begin
      errors++;
      $display("FAIL r_type_add: got v=%b %h want v=1 %h", out_valid, obs,
               {7'h33, 7'h00, 3'h0, 32'hA, 32'h3, 5'd7});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL r_type_consumed: got %b want 0", out_valid);
    end
  endtask

  task automatic test_i_type_back_to_back();
    idle();
    in_valid = 1'b1;
    instr = ADDI_X1_M1;
    tick();
    instr = SRAI_X2_X1_4;
    checks++;
    if (out_valid !== 1'b1 || obs !== {7'h13, 7'h00, 3'h0, 32'h0, 32'hFFFF_FFFF, 5'd1}) begin
      errors++;
      $display("FAIL i_type_addi: got v=%b %h want v=1 %h", out_valid, obs,
               {7'h13, 7'h00, 3'h0, 32'h0, 32'hFFFF_FFFF, 5'd1});
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || obs !== {7'h13, 7'h20, 3'h5, 32'h0, 32'h4, 5'd2}) begin
      errors++;
      $display("FAIL i_type_srai: got v=%b %h want v=1 %h", out_valid, obs,
               {7'h13, 7'h20, 3'h5, 32'h0, 32'h4, 5'd2});
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    in_valid = 1'b1;
    instr = ADD_X7_X5_X6;
    wb_en = 1'b1;
    wb_rd = 5'd5;
    wb_data = 32'h1234;
    tick();
    checks++;
    if (obs !== {7'h33, 7'h00, 3'h0, 32'h1234, 32'h3, 5'd7}) begin
      errors++;
      $display("FAIL bypass_rs1: got %h want %h", obs, {7'h33, 7'h00, 3'h0, 32'h1234, 32'h3, 5'd7});
    end
    instr = ADD_X7_X0_X6;
    wb_rd = 5'd0;
    wb_data = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (obs !== {7'h33, 7'h00, 3'h0, 32'h0, 32'h3, 5'd7}) begin
      errors++;
      $display("FAIL bypass_x0: got %h want %h", obs, {7'h33, 7'h00, 3'h0, 32'h0, 32'h3, 5'd7});
    end
    wb_en = 1'b0;
    instr = ADD_X7_X5_X6;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_written: got a=%h want 00001234", a);
    end
    tick();
  endtask

  task automatic test_hold();
    op_t snap;
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = ADD_X7_X5_X6;
    tick();
    snap = obs;
    for (int i = 0; i < 3; i++) begin
      instr = rand_instr(1'b0);
      wb_en = 1'b1;
      wb_rd = 5'd5;
      wb_data = $urandom;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || obs !== snap || obs !== m_out) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got v=%b %h want v=1 %h", i, out_valid, obs, snap);
      end
    end
    wb_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = rand_instr(1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL release_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || obs !== m_out) begin
        errors++;
        $display("FAIL release_transfer[%0d]: got v=%b %h want v=1 %h", i, out_valid, obs, m_out);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_illegal();
    idle();
    in_valid = 1'b1;
    instr = LW_X5;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || illegal_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL illegal_drop: got v=%b cnt=%0d want v=0 cnt=1", out_valid, illegal_cnt);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = ADD_X7_X5_X6;
    tick();
    out_ready = 1'b1;
    instr = LW_X5;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || illegal_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL illegal_with_consume: got v=%b cnt=%0d want v=0 cnt=2", out_valid, illegal_cnt);
    end
    write_reg(5'd5, 32'h77);
    idle();
    rst = 1'b1;
    in_valid = 1'b1;
    instr = LW_X5;
    tick();
    checks++;
    if (out_valid !== 1'b0 || illegal_cnt !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_reset: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1",
               out_valid, illegal_cnt, in_ready);
    end
    rst = 1'b0;
    instr = ADD_X7_X5_X6;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || a !== 32'd0 || b !== 32'd0) begin
      errors++;
      $display("FAIL reset_clears_rf: got v=%b a=%h b=%h want v=1 a=0 b=0", out_valid, a, b);
    end
    tick();
  endtask

  task automatic test_saturate();
    int want;
    idle();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = LW_X5;
      want = (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
      tick();
      checks++;
      if (illegal_cnt !== CW'(want)) begin
        errors++;
        $display("FAIL saturate[%0d]: got %0d want %0d", i, illegal_cnt, want);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      instr = rand_instr(1'b1);
      wb_en = $urandom_range(0, 1);
      wb_rd = $urandom_range(0, 7);
      wb_data = $urandom;
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, !m_valid || out_ready);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || illegal_cnt !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL rand_state[%0d]: got v=%b cnt=%0d want v=%b cnt=%0d",
                 i, out_valid, illegal_cnt, m_valid, m_cnt);
      end
      if (m_valid) begin
        checks++;
        if (obs !== m_out) begin
          errors++;
          $display("FAIL rand_out[%0d]: got %h want %h", i, obs, m_out);
        end
      end
    end
    idle();
  endtask

  initial begin
    m_valid = 1'b0;
    m_out = '0;
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_r_type();
    test_i_type_back_to_back();
    test_bypass();
    test_hold();
    test_illegal();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: CNT_W, 16, width of the saturating illegal-instruction counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream has an instruction on instr.
REQ-005 Port: in_ready  output  1  block accepts instr this cycle.
REQ-006 Port: instr  input  32  RV32I instruction word.
REQ-007 Port: wb_en  input  1  register-file write enable from writeback.
REQ-008 Port: wb_rd  input  5  write address.
REQ-009 Port: wb_data  input  32  write data.
REQ-010 Port: out_valid  output  1  registered ALU operation is available.
REQ-011 Port: out_ready  input  1  ALU stage consumes the output this cycle.
REQ-012 Port: opcode  output  7  registered opcode for the ALU decoder.
REQ-013 Port: funct7  output  7  registered funct7 field.
REQ-014 Port: funct3  output  3  registered funct3 field.
REQ-015 Port: a  output  32  registered operand A (rs1 value).
REQ-016 Port: b  output  32  registered operand B (rs2 value or immediate).
REQ-017 Port: rd  output  5  registered destination register index.
REQ-018 Port: illegal_cnt  output  CNT_W  count of dropped non-ALU instructions.

Function
REQ-019 Register file: 32 x 32 bits; read of x0 returns 0; writes to x0 are ignored.
REQ-020 Write: wb_en=1 and wb_rd!=0 writes wb_data at the clock edge, independent of the handshake.
REQ-021 Handshake: in_ready = !out_valid || out_ready; transfer occurs when in_valid && in_ready.
REQ-022 Output transfer occurs when out_valid && out_ready; outputs are held stable while out_valid=1 and out_ready=0.
REQ-023 Latency: an instruction accepted at edge N appears with out_valid=1 after edge N; throughput is 1 per cycle when out_ready=1.
REQ-024 R-type (opcode 0110011): a=RF[instr[19:15]], b=RF[instr[24:20]], funct7=instr[31:25], funct3=instr[14:12], rd=instr[11:7].
REQ-025 I-type (opcode 0010011): a=RF[rs1]; b=sign-extended instr[31:20]; funct3=instr[14:12].
REQ-026 I-type funct7: instr[31:25] when funct3 is 001 or 101 (shift); otherwise 0000000.
REQ-027 I-type shift b: zero-extended instr[24:20].
REQ-028 Bypass: if a read index equals wb_rd, wb_en=1 and the index is nonzero in the accept cycle, the operand takes wb_data.
REQ-029 Captured operands are not refreshed by later writebacks while held.
REQ-030 Accepted instruction with any other opcode: dropped, no output; the output register keeps its current contents and out_valid state.
REQ-031 Dropped instruction: illegal_cnt increments by 1, saturating at 2^CNT_W-1.
REQ-032 Accept and consume in the same cycle: new instruction replaces the old one and out_valid stays 1; dropped instruction with consume clears out_valid.

Reset
REQ-033 rst=1 at an edge: out_valid=0; opcode, funct7, funct3, a, b and rd=0; illegal_cnt=0; all RF entries=0.
REQ-034 rst overrides writeback and handshake in the same cycle; a held output is discarded.
REQ-035 in_ready=1 during and after reset (out_valid=0).

Verification
REQ-036 Write x5=0x0000_000A, x6=0x0000_0003, send add x7,x5,x6 (0x006283B3) -> next cycle out_valid=1, opcode=0x33, funct3=0, funct7=0, a=0xA, b=3, rd=7.
REQ-037 Send addi x1,x0,-1 (0xFFF00093) -> a=0, b=0xFFFF_FFFF, funct7=0, rd=1.
REQ-038 Send srai x2,x1,4 (0x4040D113) -> funct7=0x20, funct3=5, b=4.
REQ-039 Set wb_en=1, wb_rd=5, wb_data=0x1234 in the same cycle that add x7,x5,x6 is accepted -> a=0x1234; also wb_rd=0 -> read of x0 remains 0.
REQ-040 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged; release -> one transfer per cycle.
REQ-041 Send lw (opcode 0000011) -> no out_valid and illegal_cnt=1; then assert rst -> out_valid=0, illegal_cnt=0, x5 reads 0.
